des_sbox_serial: RTL and testbench
==================================

Name: des_sbox_serial

Overview:
- Downstream consumer of the 48-bit expansion permutation output.
- Completes the DES f-function:
  - XORs the expanded right half with the 48-bit round subkey.
  - Evaluates the eight S-boxes, serialised over several cycles to save FPGA LUTs.
  - Applies the 32-bit P permutation.
- Valid/ready handshake on both sides, so it sits between the expansion stage and the Feistel round controller.

Parameters:
- SBOX_PER_CYCLE, 1, S-boxes evaluated per clock. Legal values are 1, 2, 4, 8; anything else is an elaboration error.
- Derived: NSTEP = 8/SBOX_PER_CYCLE, the number of lookup cycles.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  EXP and SUBKEY are valid.
- in_ready  out  1  block can accept an operand.
- EXP  in  48 [48:1]  expansion permutation output. Index n = DES bit n (bit 1 = first DES bit).
- SUBKEY  in  48 [48:1]  round subkey, same bit numbering.
- out_valid  out  1  F holds a result.
- out_ready  in  1  consumer accepts F.
- F  out  32 [32:1]  f-function result P(S(EXP^SUBKEY)). Index n = DES bit n.
- busy  out  1  high in SUB or DONE.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE, cnt=0, X=0, S=0, F=0.
  - out_valid=0, busy=0, in_ready=1 after reset.
- States:
  - IDLE: in_ready=1. On in_valid at a rising edge, latch X <= EXP ^ SUBKEY, clear S, cnt <= 0, go to SUB.
  - SUB: in_ready=0. Each edge evaluates S-boxes j = cnt*SBOX_PER_CYCLE+1 … (cnt+1)*SBOX_PER_CYCLE.
    - S-box j input = X[6j-5..6j].
    - row = {X[6j-5], X[6j]}, col = X[6j-4..6j-1]. The lower DES index is the MSB of row and col.
    - 4-bit output written to S[4j-3..4j]; S[4j-3] is its MSB.
    - At cnt=NSTEP-1 the same edge also loads F[k] <= S_final[P[k]] for k=1..32 (final S-box values included) and moves to DONE. Otherwise cnt++.
  - DONE: out_valid=1, F stable. When out_valid && out_ready at an edge, go to IDLE; out_valid drops the next cycle.
- Latency: accept edge T → out_valid high after edge T+NSTEP (8 cycles for the default). Throughput is one result per NSTEP+2 cycles minimum.
- No bypass or overlap:
  - in_valid during SUB or DONE is ignored (in_ready=0). The upstream stage must hold its data.
  - An accept in IDLE and a release in DONE never coincide.
- F changes only on the final SUB edge. It holds its value while out_valid=1 and out_ready=0 indefinitely.
- EXP and SUBKEY may change freely after the accept edge. Only the latched X is used.
- Reset mid-operation (SUB or DONE): immediate return to reset values. The partial result is discarded and no out_valid pulse occurs.
- P table (F[k] takes S[n]), k=1..32:
  - k=1..16: 16 7 20 21 29 12 28 17 1 15 23 26 5 18 31 10
  - k=17..32: 2 8 24 14 32 27 3 9 19 13 30 6 22 11 4 25
- S-box contents: the standard FIPS 46-3 S1..S8 tables.

Decomposition:
- Shared package des_pkg:
  - S-box tables as a constant array [1:8][0:3][0:15] of 4 bits.
  - P table as a constant array [1:32].
  - State encoding IDLE/SUB/DONE.
  - Shared later with the round controller and the key schedule.
- One sub-module, des_sbox_lut:
  - Purely combinational; inputs 3-bit box index and 6-bit chunk, output 4-bit value.
  - Instantiated SBOX_PER_CYCLE times, each addressed by cnt.

Test Plan (bit strings in DES order, bit 1 first; F is also given as a big-endian DES-order hex word):
- Zero operand: EXP=0, SUBKEY=0, SBOX_PER_CYCLE=1 → out_valid 8 cycles after accept, S=1110 1111 1010 0111 0010 1100 0100 1101. F equals P applied to that S; the bench model computes it from the tables.
- FIPS round-1 vector:
  - EXP = 011110 100001 010101 010101 011110 100001 010101 010101
  - SUBKEY = 000110 110000 001011 101111 111111 000111 000001 110010
  - Expected: S = 0x5C82B597, F = 0x234AA9BB (0010 0011 0100 1010 1010 1001 1011 1011).
- Same vector with SBOX_PER_CYCLE = 2, 4 and 8 → identical F, with latency 4, 2 and 1 cycles respectively.
- Back-pressure: hold out_ready=0 for 20 cycles in DONE → F stable, in_ready=0. Toggle EXP and in_valid meanwhile → ignored. Release → out_valid low the next cycle, in_ready=1.
- Reset mid-SUB: assert rst_n=0 at cnt=3 → F=0, out_valid=0, in_ready=1 asynchronously. Then rerun the FIPS vector → F=0x234AA9BB.
- Back-to-back: in_valid held high with two vectors (the two above) → two results in order, each following the NSTEP+2 spacing, with no data corruption.

Source files
------------

// File: rtl/des_pkg.sv
// Shared DES constants: S-box contents, P permutation and the f-function
// state encoding. Also used by the round controller and key schedule.
package des_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SUB  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // One S-box row: sixteen 4-bit entries, entry 0 is the leftmost nibble.
  typedef logic [0:15][3:0] sbox_row_t;

  // FIPS 46-3 S1..S8, indexed [box][row][col].
  localparam sbox_row_t SBOX [1:8][0:3] = '{
    '{64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D},
    '{64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9},
    '{64'hA09E63F51DC7B428, 64'hD70934A628E5CBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C},
    '{64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E},
    '{64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453},
    '{64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D},
    '{64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C},
    '{64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B}
  };

  // P permutation: output bit k takes S-box output bit P_TABLE[k] (DES numbering).
  localparam int unsigned P_TABLE [1:32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25
  };

endpackage

// File: rtl/des_sbox_lut.sv
// Single DES S-box lookup. chunk_i[5] is the first DES bit of the 6-bit group.
module des_sbox_lut
  import des_pkg::*;
(
  input  logic [2:0] box_i,    // 0..7 selects S1..S8
  input  logic [5:0] chunk_i,
  output logic [3:0] val_o     // val_o[3] is the first DES output bit
);

  logic [3:0] box_n;
  logic [1:0] row;
  logic [3:0] col;
  sbox_row_t  row_bits;

  assign box_n = {1'b0, box_i} + 4'd1;
  assign row   = {chunk_i[5], chunk_i[0]};
  assign col   = chunk_i[4:1];

  // Table fetch: select the row, then the column nibble.
  always_comb begin
    row_bits = SBOX[box_n][row];
    val_o    = row_bits[col];
  end

endmodule

// File: rtl/des_sbox_serial.sv
// DES f-function back end: X = EXP ^ SUBKEY, serialised S-box evaluation,
// then P permutation. Valid/ready on both sides, one operand in flight.
module des_sbox_serial
  import des_pkg::*;
#(
  parameter int SBOX_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [48:1] EXP,
  input  logic [48:1] SUBKEY,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [32:1] F,
  output logic        busy
);

  localparam int NSTEP = 8 / SBOX_PER_CYCLE;
  localparam int CW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;

  if (SBOX_PER_CYCLE != 1 && SBOX_PER_CYCLE != 2 &&
      SBOX_PER_CYCLE != 4 && SBOX_PER_CYCLE != 8) begin : g_bad_param
    $error("des_sbox_serial: SBOX_PER_CYCLE must be 1, 2, 4 or 8");
  end

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [48:1]   x_q, x_d;
  logic [32:1]   s_q, s_d;
  logic [32:1]   f_q, f_d;

  logic [5:0]    box_chunk [0:7];
  logic [5:0]    lane_cand [0:SBOX_PER_CYCLE-1][0:NSTEP-1];
  logic [5:0]    lane_chunk[0:SBOX_PER_CYCLE-1];
  logic [2:0]    lane_box  [0:SBOX_PER_CYCLE-1];
  logic [3:0]    lane_val  [0:SBOX_PER_CYCLE-1];
  logic [32:1]   s_sub;
  logic [32:1]   f_perm;

  // Regroup X into eight 6-bit chunks, first DES bit of each group as MSB.
  for (genvar b = 0; b < 8; b++) begin : g_chunk
    for (genvar t = 0; t < 6; t++) begin : g_bit
      assign box_chunk[b][5-t] = x_q[6*b+1+t];
    end
  end

  // Each lane serves boxes g, g+SPC, g+2*SPC, ...; cnt picks which one.
  for (genvar g = 0; g < SBOX_PER_CYCLE; g++) begin : g_lane
    for (genvar c = 0; c < NSTEP; c++) begin : g_cand
      assign lane_cand[g][c] = box_chunk[c*SBOX_PER_CYCLE+g];
    end
    assign lane_chunk[g] = lane_cand[g][cnt_q];
    assign lane_box[g]   = 3'(int'(cnt_q) * SBOX_PER_CYCLE + g);

    des_sbox_lut u_lut (
      .box_i   (lane_box[g]),
      .chunk_i (lane_chunk[g]),
      .val_o   (lane_val[g])
    );
  end

  // S with this cycle's lookups merged in; untouched nibbles keep their value.
  for (genvar b = 0; b < 8; b++) begin : g_merge
    logic       hit;
    logic [3:0] nib;
    assign hit = (cnt_q == CW'(b / SBOX_PER_CYCLE));
    assign nib = hit ? lane_val[b % SBOX_PER_CYCLE]
                     : {s_q[4*b+1], s_q[4*b+2], s_q[4*b+3], s_q[4*b+4]};
    for (genvar t = 0; t < 4; t++) begin : g_bit
      assign s_sub[4*b+1+t] = nib[3-t];
    end
  end

  // P permutation of the merged S, so the final lookups feed F on the same edge.
  for (genvar k = 1; k <= 32; k++) begin : g_perm
    assign f_perm[k] = s_sub[P_TABLE[k]];
  end

  // Next-state and datapath control.
  always_comb begin
    // NOTE: every target gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    s_d     = s_q;
    f_d     = f_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          x_d     = EXP ^ SUBKEY;
          s_d     = '0;
          cnt_d   = '0;
          state_d = ST_SUB;
        end
      end
      ST_SUB: begin
        s_d = s_sub;
        if (cnt_q == CW'(NSTEP - 1)) begin
          f_d     = f_perm;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      s_q     <= '0;
      f_q     <= '0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      s_q     <= s_d;
      f_q     <= f_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_SUB) || (state_q == ST_DONE);
  assign F         = f_q;

endmodule

// File: tb/tb_des_sbox_serial.sv
// Directed bench for des_sbox_serial: four instances (1, 2, 4, 8 S-boxes
// per cycle) share clock, reset and operand buses; each has its own handshake.
module tb_des_sbox_serial;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [48:1] EXP = '0;
  logic [48:1] SUBKEY = '0;

  logic        in_valid  [4];
  logic        out_ready [4];
  logic        in_ready_w  [4];
  logic        out_valid_w [4];
  logic        busy_w      [4];
  logic [32:1] f_w         [4];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 4; gi++) begin : g_dut
    des_sbox_serial #(.SBOX_PER_CYCLE(1 << gi)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid[gi]),
      .in_ready  (in_ready_w[gi]),
      .EXP       (EXP),
      .SUBKEY    (SUBKEY),
      .out_valid (out_valid_w[gi]),
      .out_ready (out_ready[gi]),
      .F         (f_w[gi]),
      .busy      (busy_w[gi])
    );
  end

  // Independent copy of the P table for the reference model.
  localparam int P_BENCH [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25
  };

  // Written bit string (first DES bit leftmost) -> DES-indexed vector.
  function automatic logic [48:1] des48(input logic [47:0] b);
    logic [48:1] r;
    for (int n = 1; n <= 48; n++) r[n] = b[48-n];
    return r;
  endfunction

  // DES-indexed F -> big-endian DES-order hex word.
  function automatic logic [31:0] hex32(input logic [32:1] f);
    logic [31:0] r;
    for (int n = 1; n <= 32; n++) r[32-n] = f[n];
    return r;
  endfunction

  // Reference P permutation on hex words: F[k] = S[P[k]] in DES numbering.
  function automatic logic [31:0] p_model(input logic [31:0] s_hex);
    logic [31:0] r;
    for (int k = 1; k <= 32; k++) r[32-k] = s_hex[32-P_BENCH[k-1]];
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // All tasks start and end 1 ns after a rising edge.
  task automatic start_op(input int i, input logic [48:1] e, input logic [48:1] k);
    for (int c = 0; c < 20 && !in_ready_w[i]; c++) begin
      @(posedge clk); #1;
    end
    check("accept_ready", 64'(in_ready_w[i]), 64'd1);
    EXP = e;
    SUBKEY = k;
    in_valid[i] = 1'b1;
    @(posedge clk); #1;
    in_valid[i] = 1'b0;
    EXP = 48'({$urandom(), $urandom()});
    SUBKEY = 48'({$urandom(), $urandom()});
    check("accept_busy", 64'(busy_w[i]), 64'd1);
  endtask

  task automatic wait_result(input int i, input int lat, input logic [31:0] f_hex, input string name);
    int c = 0;
    while (!out_valid_w[i] && c < 50) begin
      @(posedge clk); #1;
      c++;
    end
    check({name, "_latency"}, 64'(c), 64'(lat));
    check({name, "_F"}, 64'(hex32(f_w[i])), 64'(f_hex));
    check({name, "_in_ready"}, 64'(in_ready_w[i]), 64'd0);
  endtask

  task automatic release_op(input int i);
    out_ready[i] = 1'b1;
    @(posedge clk); #1;
    out_ready[i] = 1'b0;
    check("release_out_valid", 64'(out_valid_w[i]), 64'd0);
    check("release_in_ready", 64'(in_ready_w[i]), 64'd1);
  endtask

  typedef struct {
    string       name;
    logic [47:0] exp_b;
    logic [47:0] key_b;
    logic [31:0] f_hex;
    int          idx;
    int          lat;
  } vec_t;

  localparam logic [47:0] FIPS_EXP = 48'b011110_100001_010101_010101_011110_100001_010101_010101;
  localparam logic [47:0] FIPS_KEY = 48'b000110_110000_001011_101111_111111_000111_000001_110010;
  localparam logic [31:0] FIPS_F   = 32'h234AA9BB;
  localparam logic [31:0] ZERO_S   = 32'b1110_1111_1010_0111_0010_1100_0100_1101;

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    vec_t        vecs [5];
    logic [31:0] zero_f;
    logic [31:0] held_f;
    logic        bad;

    zero_f = p_model(ZERO_S);
    vecs[0] = '{"zero_spc1", 48'd0,    48'd0,    zero_f, 0, 8};
    vecs[1] = '{"fips_spc1", FIPS_EXP, FIPS_KEY, FIPS_F, 0, 8};
    vecs[2] = '{"fips_spc2", FIPS_EXP, FIPS_KEY, FIPS_F, 1, 4};
    vecs[3] = '{"fips_spc4", FIPS_EXP, FIPS_KEY, FIPS_F, 2, 2};
    vecs[4] = '{"fips_spc8", FIPS_EXP, FIPS_KEY, FIPS_F, 3, 1};

    for (int i = 0; i < 4; i++) begin
      in_valid[i] = 1'b0;
      out_ready[i] = 1'b0;
    end

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready_w[0]), 64'd1);
    check("rst_out_valid", 64'(out_valid_w[0]), 64'd0);
    check("rst_busy", 64'(busy_w[0]), 64'd0);
    check("rst_F", 64'(hex32(f_w[0])), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors across all four widths.
    for (int v = 0; v < 5; v++) begin
      start_op(vecs[v].idx, des48(vecs[v].exp_b), des48(vecs[v].key_b));
      wait_result(vecs[v].idx, vecs[v].lat, vecs[v].f_hex, vecs[v].name);
      release_op(vecs[v].idx);
    end

    // Back-pressure: hold DONE for 20 cycles while poking the input side.
    start_op(0, des48(FIPS_EXP), des48(FIPS_KEY));
    wait_result(0, 8, FIPS_F, "bp");
    held_f = hex32(f_w[0]);
    for (int c = 0; c < 20; c++) begin
      in_valid[0] = c[0];
      EXP = 48'({$urandom(), $urandom()});
      @(posedge clk); #1;
      check("bp_F_stable", 64'(hex32(f_w[0])), 64'(FIPS_F));
      check("bp_out_valid", 64'(out_valid_w[0]), 64'd1);
      check("bp_in_ready", 64'(in_ready_w[0]), 64'd0);
    end
    in_valid[0] = 1'b0;
    release_op(0);
    check("bp_F_after_release", 64'(hex32(f_w[0])), 64'(held_f));

    // Reset mid-SUB at cnt=3, then rerun.
    start_op(0, des48(FIPS_EXP), des48(FIPS_KEY));
    repeat (3) begin
      @(posedge clk); #1;
    end
    #2 rst_n = 1'b0;
    #1;
    check("midrst_F", 64'(hex32(f_w[0])), 64'd0);
    check("midrst_out_valid", 64'(out_valid_w[0]), 64'd0);
    check("midrst_in_ready", 64'(in_ready_w[0]), 64'd1);
    check("midrst_busy", 64'(busy_w[0]), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (out_valid_w[0]) bad = 1'b1;
    end
    check("midrst_no_out_valid", 64'(bad), 64'd0);
    start_op(0, des48(FIPS_EXP), des48(FIPS_KEY));
    wait_result(0, 8, FIPS_F, "midrst_rerun");
    release_op(0);

    // Back-to-back with in_valid and out_ready held high.
    out_ready[0] = 1'b1;
    EXP = '0;
    SUBKEY = '0;
    in_valid[0] = 1'b1;
    @(posedge clk); #1;
    EXP = des48(FIPS_EXP);
    SUBKEY = des48(FIPS_KEY);
    check("b2b_first_busy", 64'(busy_w[0]), 64'd1);
    wait_result(0, 8, zero_f, "b2b_first");
    @(posedge clk); #1;
    check("b2b_release_out_valid", 64'(out_valid_w[0]), 64'd0);
    check("b2b_release_in_ready", 64'(in_ready_w[0]), 64'd1);
    @(posedge clk); #1;
    check("b2b_second_busy", 64'(busy_w[0]), 64'd1);
    in_valid[0] = 1'b0;
    EXP = 48'({$urandom(), $urandom()});
    wait_result(0, 8, FIPS_F, "b2b_second");
    @(posedge clk); #1;
    out_ready[0] = 1'b0;
    check("b2b_end_out_valid", 64'(out_valid_w[0]), 64'd0);
    check("b2b_end_in_ready", 64'(in_ready_w[0]), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
